dmem_responder: RTL and testbench

Data-memory responder for the 5-stage pipeline: the target end of the MEM-stage load/store interface. Accepts one load or store per request, holds the pipeline with `busywait` for a configurable number of cycles, then performs byte/half/word access with RISC-V alignment and sign-extension rules. Also decodes one memory-mapped LED register.

---
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: stalls for LATENCY cycles, then performs a
// byte/half/word load or store into local RAM or the memory-mapped LED register.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        busywait,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [14:0] led_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     led_q;
  logic [3:0][7:0] ram [DEPTH_WORDS];

  logic [AW-1:0]   idx_d;
  logic            led_hit_d, in_range_d, illegal_d, misalign_d, err_d;
  logic [31:0]     rd_word_d, lane_d, load_d;
  logic [3:0]      be_d;
  logic [3:0][7:0] wword_d;
  logic [CW-1:0]   cnt_dec_d;
  logic            access_d;

  always_comb begin
    idx_d      = mem_addr[AW+1:2];
    led_hit_d  = mem_addr[31:2] == LED_ADDR[31:2];
    in_range_d = {1'b0, mem_addr} < RAM_BYTES;
    illegal_d  = (mem_funct3 inside {3'b011, 3'b110, 3'b111}) || (mem_write && mem_funct3[2]);
    misalign_d = (mem_funct3[1:0] == 2'b01 && mem_addr[0]) ||
                 (mem_funct3[1:0] == 2'b10 && mem_addr[1:0] != 2'b00);
    err_d      = illegal_d || misalign_d || !(led_hit_d || in_range_d);

    rd_word_d  = led_hit_d ? led_q : ram[idx_d];
    lane_d     = rd_word_d >> {mem_addr[1:0], 3'b000};
    case (mem_funct3)
      3'b000:  load_d = {{24{lane_d[7]}}, lane_d[7:0]};
      3'b001:  load_d = {{16{lane_d[15]}}, lane_d[15:0]};
      3'b100:  load_d = {24'h0, lane_d[7:0]};
      3'b101:  load_d = {16'h0, lane_d[15:0]};
      default: load_d = rd_word_d;
    endcase

    // Store data is replicated across lanes; byte enables pick the live lanes.
    case (mem_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << mem_addr[1:0];
        wword_d = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wword_d = {2{mem_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wword_d = mem_wdata;
      end
    endcase

    // The access lands on the edge where the remaining wait count hits zero.
    cnt_dec_d = cnt_q - 1'b1;
    access_d  = reset && (((state_q == IDLE) && mem_req && (LATENCY == 1)) ||
                          ((state_q == WAIT) && (cnt_dec_d == '0)));

    busywait  = reset && (((state_q == IDLE) && mem_req) || (state_q == WAIT));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (mem_req) begin
          cnt_q   <= CW'(LATENCY - 1);
          state_q <= (LATENCY > 1) ? WAIT : DONE;
        end
        WAIT: begin
          cnt_q <= cnt_dec_d;
          if (cnt_dec_d == '0) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
      if (access_d) begin
        err_q   <= err_d;
        rdata_q <= (err_d || mem_write) ? 32'h0 : load_d;
        if (mem_write && !err_d && led_hit_d)
          for (int b = 0; b < 4; b++)
            if (be_d[b]) led_q[b*8 +: 8] <= wword_d[b];
      end
    end
  end

  // RAM has no reset; access_d is already gated so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (access_d && mem_write && !err_d && !led_hit_d)
      for (int b = 0; b < 4; b++)
        if (be_d[b]) ram[idx_d][b] <= wword_d[b];
  end

  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;
  assign led_out   = led_q[14:0];
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected completions, a monitor
// pops and compares them whenever the responder reaches its DONE cycle.
module tb_dmem_responder;
  localparam int          LATENCY  = 2;
  localparam logic [31:0] LED_ADDR = 32'hFFFF_FFF0;
  localparam logic [2:0]  F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req = 1'b0, mem_write = 1'b0;
  logic [2:0]  mem_funct3 = 3'b0;
  logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
  logic        busywait;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [14:0] led_out;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LATENCY), .LED_ADDR(LED_ADDR)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busywait(busywait), .mem_rdata(mem_rdata), .mem_err(mem_err), .led_out(led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    logic [14:0] led;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [14:0] led_exp = 15'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: DONE is the first non-busy cycle after a busy one with reset released.
  initial begin
    logic prev_bw, prev_rst;
    exp_t e;
    prev_bw = 1'b0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && prev_rst && prev_bw && !busywait) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: rdata %h err %b with empty scoreboard", mem_rdata, mem_err);
        end else begin
          e = sb.pop_front();
          if (e.chk_rd) check({e.name, "_rdata"}, mem_rdata, e.rdata);
          check({e.name, "_err"}, {31'h0, mem_err}, {31'h0, e.err});
          check({e.name, "_led"}, {17'h0, led_out}, {17'h0, e.led});
        end
      end
      prev_bw = busywait;
      prev_rst = reset;
    end
  end

  task automatic acc(input string nm, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd);
    int n;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_write = wr; mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
    sb.push_back('{nm, exp_rd, exp_err, chk_rd, led_exp});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busywait) break;
      n++;
    end
    check({nm, "_busy_cycles"}, n, LATENCY);
    mem_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a request asserted: busywait must stay low.
    reset = 1'b0;
    mem_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busywait", {31'h0, busywait}, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_err", {31'h0, mem_err}, 32'h0);
    check("rst_led", {17'h0, led_out}, 32'h0);
    mem_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    acc("sw10", 1, F_W, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    acc("lw10", 0, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1);

    acc("sw20", 1, F_W, 32'h20, 32'h11223344, 32'h0, 0, 0);
    acc("sb21", 1, F_B, 32'h21, 32'h00000080, 32'h0, 0, 0);
    acc("lb21", 0, F_B, 32'h21, 32'h0, 32'hFFFFFF80, 0, 1);
    acc("lbu21", 0, F_BU, 32'h21, 32'h0, 32'h00000080, 0, 1);
    acc("lw20", 0, F_W, 32'h20, 32'h0, 32'h11228044, 0, 1);

    acc("sw30", 1, F_W, 32'h30, 32'h0, 32'h0, 0, 0);
    acc("sh32", 1, F_H, 32'h32, 32'h00008001, 32'h0, 0, 0);
    acc("lh32", 0, F_H, 32'h32, 32'h0, 32'hFFFF8001, 0, 1);
    acc("lhu32", 0, F_HU, 32'h32, 32'h0, 32'h00008001, 0, 1);
    acc("lw30", 0, F_W, 32'h30, 32'h0, 32'h80010000, 0, 1);

    acc("sw40", 1, F_W, 32'h40, 32'hCAFEF00D, 32'h0, 0, 0);
    acc("lw13_misal", 0, F_W, 32'h13, 32'h0, 32'h0, 1, 1);
    acc("sh41_misal", 1, F_H, 32'h41, 32'h0000FFFF, 32'h0, 1, 1);
    acc("lw40", 0, F_W, 32'h40, 32'h0, 32'hCAFEF00D, 0, 1);
    acc("f3_011", 0, 3'b011, 32'h40, 32'h0, 32'h0, 1, 1);
    acc("sbu_store", 1, F_BU, 32'h40, 32'h000000AA, 32'h0, 1, 1);
    acc("lw_oor", 0, F_W, 32'h1000, 32'h0, 32'h0, 1, 1);
    acc("lw40_again", 0, F_W, 32'h40, 32'h0, 32'hCAFEF00D, 0, 1);

    led_exp = 15'h7ABC;
    acc("sw_led", 1, F_W, LED_ADDR, 32'h00007ABC, 32'h0, 0, 0);
    acc("lw_led", 0, F_W, LED_ADDR, 32'h0, 32'h00007ABC, 0, 1);
    acc("lbu_led1", 0, F_BU, LED_ADDR + 32'd1, 32'h0, 32'h0000007A, 0, 1);
    acc("lw_led_misal", 0, F_W, LED_ADDR + 32'd2, 32'h0, 32'h0, 1, 1);

    acc("sw50", 1, F_W, 32'h50, 32'h11223344, 32'h0, 0, 0);
    acc("lw50_pre", 0, F_W, 32'h50, 32'h0, 32'h11223344, 0, 1);

    // Store aborted by reset in its WAIT cycle.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_write = 1'b1; mem_funct3 = F_W; mem_addr = 32'h50; mem_wdata = 32'h55667788;
    @(negedge clk);
    check("abort_busy_c0", {31'h0, busywait}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy_in_rst", {31'h0, busywait}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    mem_req = 1'b0;
    @(negedge clk);
    check("abort_led", {17'h0, led_out}, 32'h0);
    check("abort_rdata", mem_rdata, 32'h0);
    check("abort_busy_after", {31'h0, busywait}, 32'h0);
    led_exp = 15'h0;
    acc("lw50_post", 0, F_W, 32'h50, 32'h0, 32'h11223344, 0, 1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
